// File: rtl/project_2.sv
// SPI slave with an internal MEM_DEPTH x 8 single-port RAM.
// Frames are a routing bit followed by a 10-bit command word; read data is returned on MISO.
module project_2 #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned TXC_W      = 3;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [9:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rd_addr_flag_q, rd_addr_flag_d;
    logic             tx_busy_q, tx_busy_d;
    logic [TXC_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             miso_q, miso_d;

    logic [ADDR_SIZE-1:0] wr_addr_q;
    logic [ADDR_SIZE-1:0] rd_addr_q;
    logic [7:0]           tx_data_q;
    logic                 tx_valid_q;
    logic [7:0]           mem [MEM_DEPTH];

    // Next-state and datapath for the serial side; SS_n high always aborts to IDLE.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_flag_d = rd_addr_flag_q;
        tx_busy_d      = tx_busy_q;
        tx_cnt_d       = tx_cnt_q;
        tx_shift_d     = tx_shift_q;
        miso_d         = 1'b0;

        if (SS_n) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tx_busy_d = 1'b0;
            tx_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: state_d = CHK_CMD;
                CHK_CMD: begin
                    bit_cnt_d = '0;
                    if (!MOSI)               state_d = WRITE;
                    else if (rd_addr_flag_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                WRITE, READ_ADD: begin
                    rx_data_d = {rx_data_q[8:0], MOSI};
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        bit_cnt_d  = '0;
                        rx_valid_d = 1'b1;
                        state_d    = CHK_CMD;
                        if (state_q == READ_ADD) rd_addr_flag_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                READ_DATA: begin
                    if (bit_cnt_q < CNT_W'(FRAME_BITS)) begin
                        rx_data_d = {rx_data_q[8:0], MOSI};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) rx_valid_d = 1'b1;
                    end else if (tx_busy_q) begin
                        miso_d     = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        tx_cnt_d   = tx_cnt_q + TXC_W'(1);
                        if (tx_cnt_q == TXC_W'(7)) begin
                            tx_busy_d      = 1'b0;
                            tx_cnt_d       = '0;
                            bit_cnt_d      = '0;
                            rd_addr_flag_d = 1'b0;
                            state_d        = CHK_CMD;
                        end
                    end else if (tx_valid_q) begin
                        // Bit 7 goes out now; the remaining seven follow from the shifter.
                        miso_d     = tx_data_q[7];
                        tx_shift_d = {tx_data_q[6:0], 1'b0};
                        tx_busy_d  = 1'b1;
                        tx_cnt_d   = TXC_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_flag_q <= 1'b0;
            tx_busy_q      <= 1'b0;
            tx_cnt_q       <= '0;
            tx_shift_q     <= '0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_flag_q <= rd_addr_flag_d;
            tx_busy_q      <= tx_busy_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_shift_q     <= tx_shift_d;
            miso_q         <= miso_d;
        end
    end

    // RAM command decode: address latches and read launch.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            if (rx_valid_q) begin
                case (rx_data_q[9:8])
                    2'b00: wr_addr_q <= ADDR_SIZE'(32'(rx_data_q[7:0]) % MEM_DEPTH);
                    2'b10: rd_addr_q <= ADDR_SIZE'(32'(rx_data_q[7:0]) % MEM_DEPTH);
                    2'b11: begin
                        tx_data_q  <= mem[rd_addr_q];
                        tx_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage array is not reset.
    always_ff @(posedge clk) begin
        if (!rst_n && rx_valid_q && rx_data_q[9:8] == 2'b01) begin
            mem[wr_addr_q] <= rx_data_q[7:0];
        end
    end

    assign MISO = miso_q;

endmodule

// File: tb/tb_project_2.sv
// Directed bench for project_2: a scoreboard queue holds expected read bytes,
// a negedge monitor collects MISO after each read launch and compares.
module tb_project_2;

    logic clk = 1'b0;
    logic rst_n;
    logic SS_n;
    logic MOSI;
    logic MISO;

    always #5 clk = ~clk;

    project_2 #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    int         n_cmp       = 0;
    int         n_err       = 0;
    int         rx_pulses   = 0;
    int         miso_bad    = 0;
    int         frames_seen = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts rx_valid pulses, collects 8 MISO bits after each tx_valid, flags stray MISO.
    initial begin
        int         left;
        logic [7:0] sh;
        left = 0;
        sh   = '0;
        forever begin
            @(negedge clk);
            if (dut.rx_valid_q) rx_pulses++;
            if (left > 0) begin
                sh = {sh[6:0], MISO};
                left--;
                if (left == 0) begin
                    frames_seen++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL miso_unexpected: got 0x%0h, expected no read frame", sh);
                    end else begin
                        check("miso_frame", 32'(sh), 32'(exp_q.pop_front()));
                    end
                end
            end else begin
                if (MISO !== 1'b0) miso_bad++;
                if (dut.tx_valid_q) left = 8;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int n, input logic [15:0] bits);
        for (int i = n - 1; i >= 0; i--) begin
            SS_n = 1'b0;
            MOSI = bits[i];
            @(negedge clk);
        end
    endtask

    task automatic select_slave();
        SS_n = 1'b0;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    task automatic deselect();
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame(input logic route, input logic [9:0] data);
        send(11, {5'b0, route, data});
    endtask

    initial begin
        int base;
        rst_n = 1'b1;
        SS_n  = 1'b1;
        MOSI  = 1'b0;
        cyc(2);
        check("rst_miso", 32'(MISO), 0);
        check("rst_state", 32'(dut.state_q), 0);
        check("rst_flag", 32'(dut.rd_addr_flag_q), 0);
        check("rst_wr_addr", 32'(dut.wr_addr_q), 0);
        check("rst_rd_addr", 32'(dut.rd_addr_q), 0);
        rst_n = 1'b0;
        deselect();

        // Write path: address 0xBB then data 0xB9, back to back.
        base = rx_pulses;
        select_slave();
        frame(1'b0, 10'b00_1011_1011);
        frame(1'b0, 10'b01_1011_1001);
        deselect();
        check("wr_addr", 32'(dut.wr_addr_q), 32'h0BB);
        check("mem_bb", 32'(dut.mem[8'hBB]), 32'h0B9);
        check("wr_rx_pulses", 32'(rx_pulses - base), 2);
        check("wr_state_idle", 32'(dut.state_q), 0);

        // Read address 0xBB.
        base = rx_pulses;
        select_slave();
        frame(1'b1, 10'b10_1011_1011);
        deselect();
        check("rd_addr", 32'(dut.rd_addr_q), 32'h0BB);
        check("rd_flag_set", 32'(dut.rd_addr_flag_q), 1);
        check("ra_rx_pulses", 32'(rx_pulses - base), 1);

        // Read data: expect 0xB9 on MISO.
        exp_q.push_back(8'hB9);
        select_slave();
        frame(1'b1, 10'b11_0000_0000);
        SS_n = 1'b0;
        MOSI = 1'b0;
        cyc(9);
        deselect();
        check("rd_flag_clr", 32'(dut.rd_addr_flag_q), 0);
        check("rd_frames", 32'(frames_seen), 1);

        // Abort a write frame after 5 data bits.
        base = rx_pulses;
        select_slave();
        send(6, 16'b0_01010);
        deselect();
        cyc(2);
        check("ab_state", 32'(dut.state_q), 0);
        check("ab_bit_cnt", 32'(dut.bit_cnt_q), 0);
        check("ab_rx_pulses", 32'(rx_pulses - base), 0);
        check("ab_wr_addr", 32'(dut.wr_addr_q), 32'h0BB);
        check("ab_rd_addr", 32'(dut.rd_addr_q), 32'h0BB);
        check("ab_mem_bb", 32'(dut.mem[8'hBB]), 32'h0B9);
        check("ab_flag", 32'(dut.rd_addr_flag_q), 0);

        // Top address: write 0x5A at 0xFF and read it back.
        select_slave();
        frame(1'b0, 10'b00_1111_1111);
        frame(1'b0, 10'b01_0101_1010);
        deselect();
        check("mem_ff", 32'(dut.mem[8'hFF]), 32'h05A);
        select_slave();
        frame(1'b1, 10'b10_1111_1111);
        deselect();
        check("rd_addr_ff", 32'(dut.rd_addr_q), 32'h0FF);
        exp_q.push_back(8'h5A);
        select_slave();
        frame(1'b1, 10'b11_1010_0101);
        SS_n = 1'b0;
        MOSI = 1'b0;
        cyc(9);
        deselect();
        check("ff_flag_clr", 32'(dut.rd_addr_flag_q), 0);

        // Reset in the middle of a READ_ADD frame.
        select_slave();
        send(4, 16'b1011);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check("mr_state", 32'(dut.state_q), 0);
        check("mr_bit_cnt", 32'(dut.bit_cnt_q), 0);
        check("mr_rx_data", 32'(dut.rx_data_q), 0);
        check("mr_wr_addr", 32'(dut.wr_addr_q), 0);
        check("mr_miso", 32'(MISO), 0);
        deselect();
        cyc(2);

        check("miso_idle_zero", 32'(miso_bad), 0);
        check("frames_total", 32'(frames_seen), 2);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
